// File: rtl/jk_bank_pkg.sv
// Shared types for the JK bank arbiter: FSM states, JK command encodings
// and the JK next-state function used by every cell.
package jk_bank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] RST  = 2'b01;
    localparam logic [1:0] SET  = 2'b10;
    localparam logic [1:0] TGL  = 2'b11;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic r;
        case ({j, k})
            HOLD:    r = q;
            RST:     r = 1'b0;
            SET:     r = 1'b1;
            TGL:     r = ~q;
            default: r = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK flip-flop with a clock enable; holds its value when en is low.
module jk_cell
    import jk_bank_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (en) begin
            q <= jk_next(q, j, k);
        end
    end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter granting one JK command at a time to a bank of JK
// cells; each transaction takes IDLE -> APPLY -> ACK.
module jk_bank_arbiter
    import jk_bank_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IDX_W = $clog2(NBITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       cmd_j,
    input  logic [NREQ-1:0]       cmd_k,
    input  logic [NREQ*IDX_W-1:0] cmd_idx,
    output logic [NREQ-1:0]       gnt,
    output logic [NBITS-1:0]      q,
    output logic [NBITS-1:0]      qn,
    output logic                  busy,
    output logic                  err
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t             state;
    state_t             state_next;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   win;
    logic [PTR_W-1:0]   cand;
    logic               found;

    logic [PTR_W-1:0]   win_p0;
    logic               j_p0;
    logic               k_p0;
    logic [IDX_W-1:0]   idx_p0;
    logic               in_range;

    // Winner search starts just after the last granted requester and wraps.
    always_comb begin
        win   = ptr;
        cand  = ptr;
        found = 1'b0;
        for (int o = 1; o <= NREQ; o++) begin
            cand = PTR_W'((int'(ptr) + o) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = APPLY;
            APPLY:   state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // ---- stage p0: command latched at the end of IDLE ----
    always_ff @(posedge clk) begin
        if (state == IDLE && found) begin
            win_p0 <= win;
            j_p0   <= cmd_j[win];
            k_p0   <= cmd_k[win];
            idx_p0 <= cmd_idx[win*IDX_W +: IDX_W];
        end
    end

    assign in_range = (int'(idx_p0) < NBITS);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= PTR_W'(NREQ - 1);
            gnt <= '0;
            err <= 1'b0;
        end else begin
            gnt <= '0;
            err <= 1'b0;
            if (state == APPLY) begin
                ptr <= win_p0;
                gnt <= NREQ'(1) << win_p0;
                err <= !in_range;
            end
        end
    end

    // ---- bank update happens on the APPLY edge, alongside gnt ----
    for (genvar b = 0; b < NBITS; b++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .en  ((state == APPLY) && in_range && (idx_p0 == IDX_W'(b))),
            .j   (j_p0),
            .k   (k_p0),
            .q   (q[b])
        );
    end

    assign qn = ~q;

endmodule
